// File: rtl/mrt_wb_arbiter.sv
// mrt_wb_arbiter: round-robin arbiter that grants whole tile-writeback bursts
// from NUM_REQ render-target requesters onto one shared DRAM write port.
// Build macro WB_ARB_TIMEOUT_EN adds a stall watchdog that abandons a burst
// after TIMEOUT_CYCLES transfer-free cycles and raises a sticky timeout_o.
module mrt_wb_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*64-1:0]            req_addr_i,
  input  logic [NUM_REQ*32-1:0]            req_len_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data_i,
  input  logic [NUM_REQ-1:0]               req_last_i,
  output logic                             dram_write_req_o,
  input  logic                             dram_write_ack_i,
  output logic [63:0]                      dram_write_addr_o,
  output logic [31:0]                      dram_write_len_o,
  output logic [DATA_WIDTH-1:0]            dram_write_data_o,
  output logic                             dram_write_last_o,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id_o,
  output logic                             busy_o,
  output logic [31:0]                      burst_count_o,
  output logic                             timeout_o
);

  localparam int unsigned GW = $clog2(NUM_REQ);

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  state_t                state;
  logic [GW-1:0]         rr_ptr;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         idx;
  logic [GW-1:0]         next_ptr;
  logic                  found;
  logic [63:0]           win_addr;
  logic [31:0]           win_len;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_valid;
  logic                  own_last;
  logic                  xfer;
  logic                  xfer_last;
  logic                  stall_hit;

  // Round-robin search: first valid requester from rr_ptr upward, wrapping.
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = GW'((32'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Select the winner's burst header and the current owner's beat.
  always_comb begin
    win_addr  = '0;
    win_len   = '0;
    own_data  = '0;
    own_valid = 1'b0;
    own_last  = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (GW'(r) == pick) begin
        win_addr = req_addr_i[r*64 +: 64];
        win_len  = req_len_i[r*32 +: 32];
      end
      if (GW'(r) == grant_id_o) begin
        own_data  = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        own_valid = req_valid_i[r];
        own_last  = req_last_i[r];
      end
    end
  end

  // Beat path follows the owner combinationally while a burst is open.
  always_comb begin
    dram_write_req_o  = 1'b0;
    dram_write_data_o = '0;
    dram_write_last_o = 1'b0;
    req_ready_o       = '0;
    if (state == S_BURST) begin
      dram_write_req_o        = own_valid;
      dram_write_data_o       = own_data;
      dram_write_last_o       = own_last;
      req_ready_o[grant_id_o] = dram_write_ack_i;
    end
  end

  assign xfer      = dram_write_req_o & dram_write_ack_i;
  assign xfer_last = xfer & dram_write_last_o;
  assign busy_o    = (state == S_BURST);
  assign next_ptr  = (grant_id_o == GW'(NUM_REQ - 1)) ? '0 : grant_id_o + GW'(1);

  // Burst FSM: grant in IDLE, hold owner until its last beat (or watchdog).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      grant_id_o        <= '0;
      dram_write_addr_o <= '0;
      dram_write_len_o  <= '0;
      burst_count_o     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_valid_i) begin
            state             <= S_BURST;
            grant_id_o        <= pick;
            dram_write_addr_o <= win_addr;
            dram_write_len_o  <= win_len;
          end
        end
        S_BURST: begin
          if (xfer_last) begin
            state         <= S_IDLE;
            rr_ptr        <= next_ptr;
            burst_count_o <= burst_count_o + 32'd1;
          end else if (stall_hit) begin
            state  <= S_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [31:0] stall_cnt;

  assign stall_hit = (state == S_BURST) && !xfer &&
                     (stall_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog: count transfer-free BURST cycles, latch timeout on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      if ((state != S_BURST) || xfer || stall_hit) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (stall_hit) begin
        timeout_o <= 1'b1;
      end
    end
  end
`else
  // No watchdog: bursts are held indefinitely; flag is constant 0 and the
  // limit is referenced so both builds keep one parameter list.
  assign stall_hit = 1'b0;
  assign timeout_o = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

endmodule

// File: doc/mrt_wb_arbiter.md
MRT_WB_ARBITER -- requirements
Module: mrt_wb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of tile-writeback requesters, one per render target.
REQ-002 Parameter DATA_WIDTH, default 256: DRAM write data width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: stall limit applied when WB_ARB_TIMEOUT_EN is defined.
REQ-004 One clock; reset is asynchronous and active-low. Ports are listed below as name, direction, width, meaning.
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-008 req_ready_o  output  NUM_REQ  per-requester beat accepted.
REQ-009 req_addr_i  input  NUM_REQ x 64  burst DRAM address.
REQ-010 req_len_i  input  NUM_REQ x 32  burst length in bytes.
REQ-011 req_data_i  input  NUM_REQ x DATA_WIDTH  beat data.
REQ-012 req_last_i  input  NUM_REQ  final beat of the burst.
REQ-013 dram_write_req_o / dram_write_ack_i / dram_write_addr_o[64] / dram_write_len_o[32] / dram_write_data_o[DATA_WIDTH] / dram_write_last_o: the shared DRAM write port.
REQ-014 grant_id_o  output  $clog2(NUM_REQ)  current owner; busy_o  output  1  in BURST state.
REQ-015 burst_count_o  output  32  completed bursts; timeout_o  output  1  sticky stall flag.

Function
REQ-016 A beat transfers in a cycle where dram_write_req_o and dram_write_ack_i are both 1.
REQ-017 FSM has two states, IDLE and BURST.
- IDLE to BURST: taken on the edge after any req_valid_i bit is 1.
- BURST to IDLE: taken on the edge of a transfer with dram_write_last_o=1.
REQ-018 In IDLE, the grant goes round-robin to the first valid requester, searching from rr_ptr upward with wrap NUM_REQ-1 to 0.
- The winner is registered into grant_id_o.
- req_addr_i and req_len_i of the winner are registered into dram_write_addr_o and dram_write_len_o.
REQ-019 In BURST, outputs are combinational from the owner:
- dram_write_req_o = req_valid_i[grant]; data and last are passed through from the owner.
- req_ready_o[grant] = dram_write_ack_i; every other ready bit is 0.
REQ-020 In IDLE, dram_write_req_o=0 and req_ready_o=0, so there is one bubble cycle between bursts.
REQ-021 On a last-beat transfer:
- rr_ptr becomes (grant+1) mod NUM_REQ.
- burst_count_o increments and wraps at 2^32-1 to 0.
REQ-022 If the owner deasserts req_valid_i mid-burst, the FSM holds BURST with dram_write_req_o=0; there is no regrant until last.
REQ-023 The grant does not change during a burst, whatever other requests arrive.
REQ-024 Requests that are simultaneous with the last beat are arbitrated in the following IDLE cycle, using the updated rr_ptr.
REQ-025 A requester holding valid continuously waits at most NUM_REQ-1 bursts.

Reset
REQ-026 While rst_n=0:
- FSM=IDLE, rr_ptr=0, grant_id_o=0.
- All dram_write_* outputs are 0, req_ready_o=0, busy_o=0, burst_count_o=0, timeout_o=0.
REQ-027 Reset asserted mid-burst abandons the burst immediately; no last beat is issued.

Configuration
REQ-028 Macro WB_ARB_TIMEOUT_EN defined: a 32-bit stall counter counts BURST cycles with no transfer and clears on any transfer.
- On reaching TIMEOUT_CYCLES, timeout_o sets sticky until reset, and the FSM forces IDLE with rr_ptr advancing past the owner.
REQ-029 Macro WB_ARB_TIMEOUT_EN undefined: no counter is built, timeout_o is tied to 0, and BURST is held indefinitely.

Verification
REQ-030 Requester 0 only, 4-beat burst, ack always 1, addr 0x1000, len 128:
- busy_o is 1 for 4 cycles; 4 beats go out; dram_write_addr_o=0x1000.
- burst_count_o=1; req_ready_o[0] is 1 on exactly 4 cycles.
REQ-031 Requesters 0 and 2 valid in the same cycle, from reset: grant order is 0, 2, 0, 2; exactly one bubble cycle between bursts.
REQ-032 Requesters 1, 2 and 3 permanently valid, 1-beat bursts: grant sequence is 1, 2, 3, 1, 2, 3; none is starved.
REQ-033 Ack is held 0 for 10 cycles mid-burst:
- dram_write_req_o stays 1, data is stable, no regrant.
- After ack, the burst completes and burst_count_o increments by 1.
REQ-034 rst_n pulsed low in beat 2 of a 4-beat burst: all outputs are 0 within the same cycle; after release, FSM=IDLE and rr_ptr=0.
REQ-035 With WB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, the owner drops valid mid-burst:
- timeout_o is 1 after 8 stalled cycles; the FSM returns to IDLE.
- The next valid requester is granted.
